// File: rtl/linrec_if.sv
// linrec_if: start/result bundle between the harness and linrec_main
//   r_enable, controlArr, init_n, init_a, init_b, coef_p, coef_q : harness -> core
//   busy, w_enable, result, ovf                                 : core -> harness
interface linrec_if #(parameter int WIDTH = 64, parameter int CNT_W = 64);
    logic             r_enable;
    logic             controlArr;
    logic [CNT_W-1:0] init_n;
    logic [WIDTH-1:0] init_a;
    logic [WIDTH-1:0] init_b;
    logic [WIDTH-1:0] coef_p;
    logic [WIDTH-1:0] coef_q;
    logic             busy;
    logic             w_enable;
    logic [WIDTH-1:0] result;
    logic             ovf;
    modport master (output r_enable, controlArr, init_n, init_a, init_b, coef_p, coef_q,
                    input busy, w_enable, result, ovf);
    modport slave  (input r_enable, controlArr, init_n, init_a, init_b, coef_p, coef_q,
                    output busy, w_enable, result, ovf);
endinterface

// File: rtl/linrec_main.sv
// linrec_main: iterates (a,b) <- (p*a + q*b, a) n times and returns b
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : linrec_if.slave
//                in : r_enable (start), controlArr (unused), init_n/a/b, coef_p/q
//                out: busy (RUN/DONE), w_enable (one-cycle done pulse), result, ovf
//   Optional macro LINREC_OVF_DETECT_EN builds the sticky overflow detector;
//   without it ovf is tied low.
module linrec_main #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 64
) (
    input logic     clk,
    input logic     rst_n,
    linrec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nxt;
    logic [WIDTH-1:0] a, b, p, q, res, nxt;
    logic [CNT_W-1:0] cnt;
    logic             start, step;
    assign start = (state == IDLE) && bus.r_enable;
    assign step  = (state == RUN) && (cnt != '0);
`ifdef LINREC_OVF_DETECT_EN
    // Full-precision sum: any bit at or above WIDTH means the truncated step wrapped.
    logic [2*WIDTH:0] full;
    logic             ovf_q;
    assign full = (2*WIDTH+1)'(p) * (2*WIDTH+1)'(a) + (2*WIDTH+1)'(q) * (2*WIDTH+1)'(b);
    assign nxt  = full[WIDTH-1:0];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (start)
            ovf_q <= 1'b0;
        else if (step && |full[2*WIDTH:WIDTH])
            ovf_q <= 1'b1;
    end
    assign bus.ovf = ovf_q;
`else
    assign nxt     = p * a + q * b;
    assign bus.ovf = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (bus.r_enable ? RUN : IDLE) :
                    (state == RUN)  ? ((cnt == '0) ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a   <= '0;
            b   <= '0;
            p   <= '0;
            q   <= '0;
            cnt <= '0;
            res <= '0;
        end else if (start) begin
            a   <= bus.init_a;
            b   <= bus.init_b;
            p   <= bus.coef_p;
            q   <= bus.coef_q;
            cnt <= bus.init_n;
        end else if (step) begin
            a   <= nxt;
            b   <= a;
            cnt <= cnt - CNT_W'(1);
        end else if (state == RUN) begin
            res <= b;
        end
    end
    assign bus.busy     = (state != IDLE);
    assign bus.w_enable = (state == DONE);
    assign bus.result   = res;
endmodule

// File: tb/tb_linrec_main.sv
// tb_linrec_main: directed checks of linrec_main against hand-computed recurrence values
module tb_linrec_main;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    linrec_if #(.WIDTH(64), .CNT_W(64)) bus ();
    linrec_main #(.WIDTH(64), .CNT_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
`ifdef LINREC_OVF_DETECT_EN
    localparam logic OVF93 = 1'b1;
`else
    localparam logic OVF93 = 1'b0;
`endif
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic load(input logic [63:0] n, a, b, p, q);
        bus.init_n = n;
        bus.init_a = a;
        bus.init_b = b;
        bus.coef_p = p;
        bus.coef_q = q;
    endtask
    // Pulse a start, count edges (accepting edge = 1) until w_enable, then check the pulse ends.
    task automatic run(input string tag, input logic [63:0] n, a, b, p, q, exp_res,
                       input logic exp_ovf);
        int edges;
        load(n, a, b, p, q);
        bus.r_enable = 1'b1;
        @(posedge clk) #1;
        bus.r_enable = 1'b0;
        edges = 1;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        while (!bus.w_enable && edges < int'(n) + 10) begin
            @(posedge clk) #1;
            edges++;
        end
        check({tag, "_lat"}, 64'(edges), n + 64'd2);
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        @(posedge clk) #1;
        check({tag, "_pulse"}, 64'(bus.w_enable), 64'd0);
    endtask
    initial begin
        int pulses;
        logic [63:0] seen;
        bus.r_enable   = 1'b0;
        bus.controlArr = 1'b0;
        load(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_wen", 64'(bus.w_enable), 64'd0);
        check("rst_res", bus.result, 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk) #1;
        run("fib40", 40, 1, 0, 1, 1, 64'd102334155, 1'b0);
        run("fib0", 0, 1, 0, 1, 1, 64'd0, 1'b0);
        run("fib1", 1, 1, 0, 1, 1, 64'd1, 1'b0);
        run("pell10", 10, 1, 0, 2, 1, 64'd2378, 1'b0);
        run("jac7", 7, 1, 0, 1, 2, 64'd43, 1'b0);
        run("fib92", 92, 1, 0, 1, 1, 64'd7540113804746346429, 1'b0);
        run("fib93", 93, 1, 0, 1, 1, 64'd12200160415121876738, OVF93);
        run("fib2", 2, 1, 0, 1, 1, 64'd1, 1'b0);
        // Start request during RUN must be dropped.
        load(40, 1, 0, 1, 1);
        bus.r_enable = 1'b1;
        @(posedge clk) #1;
        bus.r_enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        load(5, 1, 0, 1, 1);
        bus.r_enable = 1'b1;
        @(posedge clk) #1;
        bus.r_enable = 1'b0;
        pulses = 0;
        seen = '0;
        repeat (60) begin
            @(posedge clk) #1;
            if (bus.w_enable) begin
                pulses++;
                seen = bus.result;
            end
        end
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_res", seen, 64'd102334155);
        run("fib5", 5, 1, 0, 1, 1, 64'd5, 1'b0);
        // Asynchronous reset mid-run aborts without a completion pulse.
        load(40, 1, 0, 1, 1);
        bus.r_enable = 1'b1;
        @(posedge clk) #1;
        bus.r_enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_res", bus.result, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk) #1;
            if (bus.w_enable || bus.busy) pulses++;
        end
        check("abort_quiet", 64'(pulses), 64'd0);
        run("restart40", 40, 1, 0, 1, 1, 64'd102334155, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
